// File: rtl/sram_1p_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port synchronous SRAM.
// Optional post-reset clear sequencer is compiled in with `define SRAM_ARB_INIT_EN;
// without it the block comes out of reset straight into RUN with init_done tied high.
module sram_1p_rr_arbiter #(
    parameter int unsigned       ADDR_W     = 9,
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       DEPTH      = 512,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,

    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,

    output logic              init_done
);

    // Last granted requester; reset to 1 so requester 0 wins the first tie.
    logic rr_last;
    logic fire0;
    logic fire1;
    logic run_c;

`ifdef SRAM_ARB_INIT_EN
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] init_cnt;
    logic [CNT_W-1:0] init_cnt_nxt;
    logic             init_done_q;

    // State, clear counter and init_done registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= INIT;
            init_cnt    <= '0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_cnt    <= init_cnt_nxt;
            init_done_q <= (state_nxt == RUN);
        end
    end

    // Walk every entry once, then hand the SRAM over to the requesters.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            INIT: begin
                init_cnt_nxt = init_cnt + CNT_W'(1);
                if (init_cnt == CNT_W'(DEPTH - 1)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign run_c     = (state == RUN);
    assign init_done = init_done_q;
`else
    // Clear sequencer absent: these parameters only shape the optional feature.
    logic cfg_unused;
    assign cfg_unused = ^{INIT_VALUE, 32'(DEPTH)};

    assign run_c     = 1'b1;
    assign init_done = 1'b1;
`endif

    // Grant decision and SRAM drive from the winner (or the clear sequencer).
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        fire0      = 1'b0;
        fire1      = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = req0_write;
        sram_addr  = req0_addr;
        sram_wdata = req0_wdata;
        if (run_c) begin
            req0_ready = !req1_valid || rr_last;
            req1_ready = !req0_valid || !rr_last;
            fire0      = req0_valid && req0_ready;
            fire1      = req1_valid && req1_ready;
            sram_en    = fire0 || fire1;
            if (fire1) begin
                sram_wmode = req1_write;
                sram_addr  = req1_addr;
                sram_wdata = req1_wdata;
            end
        end
`ifdef SRAM_ARB_INIT_EN
        else begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_cnt[ADDR_W-1:0];
            sram_wdata = INIT_VALUE;
        end
`endif
    end

    // Round-robin history and one-cycle read response strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last     <= 1'b1;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            if (fire0) begin
                rr_last <= 1'b0;
            end else if (fire1) begin
                rr_last <= 1'b1;
            end
            resp0_valid <= fire0 && !req0_write;
            resp1_valid <= fire1 && !req1_write;
        end
    end

    // The macro holds read data until the next read, so the response is a wire.
    assign resp0_rdata = sram_rdata;
    assign resp1_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_1p_rr_arbiter.sv
// Scoreboard bench for sram_1p_rr_arbiter with a behavioural SRAM macro.
// Build with or without `define SRAM_ARB_INIT_EN; the bench follows the same macro.
module tb_sram_1p_rr_arbiter;

    localparam int unsigned AW     = 9;
    localparam int unsigned DW     = 16;
    localparam int unsigned DEPTH  = 512;
    localparam logic [DW-1:0] INIT_V = 16'hA5A5;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          resp0_valid;
    logic [DW-1:0] resp0_rdata;
    logic          req1_valid, req1_ready, req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          resp1_valid;
    logic [DW-1:0] resp1_rdata;
    logic          sram_en, sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          init_done;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic mon_en = 1'b0;
    logic last_win;
    exp_t q0[$];
    exp_t q1[$];
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] sram_mem [0:DEPTH-1];
    logic [DW-1:0] sram_q;

    sram_1p_rr_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .INIT_VALUE(INIT_V)
    ) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .init_done(init_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Single-port macro: write on strobe, read data one cycle later and held.
    always @(posedge clock) begin
        if (sram_en === 1'b1) begin
            if (sram_wmode) sram_mem[sram_addr] <= sram_wdata;
            else            sram_q <= sram_mem[sram_addr];
        end
    end
    assign sram_rdata = sram_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pop the oldest expected response of requester idx and compare.
    task automatic mon(input int idx, input logic v, input logic [DW-1:0] d);
        exp_t e;
        int   n;
        n = (idx == 1) ? q1.size() : q0.size();
        if (v === 1'b1) begin
            if (n == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp%0d_unexpected: got valid=1 expected no response (cycle %0d)", idx, cyc);
            end else begin
                e = (idx == 1) ? q1.pop_front() : q0.pop_front();
                check($sformatf("resp%0d_latency", idx), 64'(cyc), 64'(e.due));
                check($sformatf("resp%0d_rdata", idx), 64'(d), 64'(e.data));
            end
        end else if (n > 0) begin
            e = (idx == 1) ? q1[0] : q0[0];
            if (e.due <= cyc) begin
                if (idx == 1) void'(q1.pop_front());
                else          void'(q0.pop_front());
                n_vec++;
                n_err++;
                $display("FAIL resp%0d_missing: got valid=%b expected 1 (cycle %0d)", idx, v, cyc);
            end
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            mon(0, resp0_valid, resp0_rdata);
            mon(1, resp1_valid, resp1_rdata);
        end
    end

    // Apply one cycle of requests; check grant and SRAM drive; record expected reads.
    task automatic drive(input logic v0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic v1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic rst);
        logic          any, win, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        exp_t          e;
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
        reset = rst;
        @(negedge clock);
        // A requester is refused only when the other one asks and it is the other's turn.
        check("req0_ready", 64'(req0_ready), 64'(!(v1 && last_win == 1'b0)));
        check("req1_ready", 64'(req1_ready), 64'(!(v0 && last_win == 1'b1)));
        any = v0 || v1;
        win = (v0 && v1) ? ~last_win : v1;
        check("sram_en", 64'(sram_en), 64'(any));
        if (any) begin
            w = win ? w1 : w0;
            a = win ? a1 : a0;
            d = win ? d1 : d0;
            check("sram_wmode", 64'(sram_wmode), 64'(w));
            check("sram_addr", 64'(sram_addr), 64'(a));
            if (w) begin
                check("sram_wdata", 64'(sram_wdata), 64'(d));
                ref_mem[a] = d;
            end else if (!rst) begin
                e.data = ref_mem[a];
                e.due  = cyc + 1;
                if (win) q1.push_back(e);
                else     q0.push_back(e);
            end
            last_win = win;
        end
        if (rst) last_win = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

`ifdef SRAM_ARB_INIT_EN
    // Expect n consecutive clear writes from address 0 while requests are refused.
    task automatic init_run(input int n);
        for (int i = 0; i < n; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(negedge clock);
            check("init_seq",
                  64'({sram_en, sram_wmode, req0_ready, req1_ready, init_done, sram_addr, sram_wdata}),
                  64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(i), INIT_V}));
            @(posedge clock);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask
`endif

    initial begin
        logic          v0, v1, w0, w1, rst;
        logic [AW-1:0] a0, a1;
        reset = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        last_win = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

`ifdef SRAM_ARB_INIT_EN
        // Clear interrupted at entry 200 must restart from address 0.
        init_run(200);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        init_run(int'(DEPTH));
        @(negedge clock);
        check("init_done_rise", 64'(init_done), 64'd1);
        check("ready_after_init", 64'(req0_ready), 64'd1);
        check("resp_after_init", 64'({resp0_valid, resp1_valid}), 64'd0);
        @(posedge clock);
        #1;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = INIT_V;
        mon_en = 1'b1;
        drive(1, 0, 9'd300, '0, 0, 0, '0, '0, 0);
        idle(1);
`else
        @(negedge clock);
        check("init_done_reset", 64'(init_done), 64'd1);
        check("req0_ready_reset", 64'(req0_ready), 64'd1);
        check("resp_valid_reset", 64'({resp0_valid, resp1_valid}), 64'd0);
        @(posedge clock);
        #1;
        mon_en = 1'b1;
`endif

        // Single requester: write then read back.
        drive(1, 1, 9'd5, 16'h1234, 0, 0, '0, '0, 0);
        drive(1, 0, 9'd5, '0, 0, 0, '0, '0, 0);
        idle(2);
        // Requester 1 alone, then contention: requester 0 must go first.
        drive(0, 0, '0, '0, 1, 1, 9'd7, 16'h0777, 0);
        idle(1);
        for (int i = 0; i < 4; i++) drive(1, 0, 9'd5, '0, 1, 0, 9'd7, '0, 0);
        idle(2);
        // Top address, write then immediate read.
        drive(0, 0, '0, '0, 1, 1, 9'd511, 16'hFFFF, 0);
        drive(1, 0, 9'd511, '0, 0, 0, '0, '0, 0);
        idle(2);
`ifndef SRAM_ARB_INIT_EN
        // Read accepted in the reset cycle produces no response.
        drive(1, 0, 9'd5, '0, 0, 0, '0, '0, 1);
        idle(2);
`endif

        for (int i = 0; i < 3000; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            w0 = $urandom_range(0, 1) == 1;
            w1 = $urandom_range(0, 1) == 1;
            a0 = ($urandom_range(0, 7) == 0) ? 9'd511 : AW'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 7) == 0) ? 9'd511 : AW'($urandom_range(0, 15));
`ifdef SRAM_ARB_INIT_EN
            rst = 1'b0;
`else
            rst = ($urandom_range(0, 199) == 0);
`endif
            drive(v0, w0, a0, DW'($urandom), v1, w1, a1, DW'($urandom), rst);
        end
        idle(3);
        check("drain_queues", 64'(q0.size() + q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_1p_rr_arbiter.md
Name: sram_1p_rr_arbiter

Overview:
- Shares one single-port synchronous SRAM macro (RW0-style: en/wmode/addr/wdata, read data one cycle after the read strobe and held until the next read) between two requesters.
- Each requester uses a valid/ready request channel and gets a fixed-latency read response.
- Round-robin arbitration, one access per cycle.
- An optional post-reset init sequencer writes a known value to every entry before the block accepts requests.

Parameters:
- ADDR_W, 9, SRAM address width
- DATA_W, 16, SRAM data width
- DEPTH, 512, number of entries; must be ≤ 2^ADDR_W
- INIT_VALUE, 0, DATA_W-bit value written to every entry during init

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 access request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  access address
- req0_wdata  in  DATA_W  write data
- resp0_valid  out  1  read data for requester 0 valid this cycle
- resp0_rdata  out  DATA_W  read data
- req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, resp1_valid, resp1_rdata: same as requester 0
- sram_en  out  1  SRAM access strobe
- sram_wmode  out  1  SRAM write mode
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data
- init_done  out  1  high once the block accepts requests

Behaviour:
- Clock and reset: one clock, "clock"; synchronous active-high reset, "reset".
- Reset values:
  - state = INIT with the feature compiled in, else RUN.
  - init_cnt = 0; rr_last = 1 (requester 0 wins the first tie).
  - resp0_valid = resp1_valid = 0.
  - init_done = 0 with the feature in, else 1 from the first post-reset cycle.
- States: INIT, RUN. No other states.
- INIT:
  - Every cycle drives sram_en=1, sram_wmode=1, sram_addr=init_cnt, sram_wdata=INIT_VALUE.
  - init_cnt increments by 1 each cycle.
  - After the write at init_cnt = DEPTH-1 → RUN, with init_done=1 registered from the next cycle.
  - req*_ready = 0 and resp*_valid = 0 throughout.
- RUN, grant logic:
  - req0_ready = !req1_valid || rr_last==1.
  - req1_ready = !req0_valid || rr_last==0.
  - Ready is independent of the requester's own valid.
  - fire_i = req_i_valid && req_i_ready; at most one fire per cycle.
- RUN, SRAM drive (combinational from the winning requester):
  - sram_en = fire0 || fire1.
  - sram_wmode, sram_addr, sram_wdata = the winner's write, addr and wdata.
  - With no fire: sram_en = 0, other SRAM outputs don't-care (drive the requester 0 fields).
- rr_last <= winner index on every fire; unchanged otherwise.
- Read response:
  - resp_i_valid <= fire_i && !req_i_write (one-cycle pulse, latency exactly 1 cycle after the accept edge).
  - resp_i_rdata = sram_rdata, combinational pass-through; only meaningful when resp_i_valid.
  - No response backpressure; the requester must sink it.
  - Writes produce no response.
- Back-to-back: a read at cycle N and any access at N+1 are both legal. The response for N is presented in N+1 alongside the new SRAM strobe.
- Same-address write then read on consecutive cycles returns the new data.
- Reset asserted mid-INIT restarts init_cnt at 0.
- Reset asserted mid-RUN drops any pending response (resp*_valid = 0 next cycle).
- init_cnt width = ADDR_W+1. No wrap occurs because INIT exits at DEPTH-1.

Optional Feature:
- Macro: SRAM_ARB_INIT_EN
- Defined: INIT state and init_cnt exist; behaviour as above. Clearing DEPTH entries takes DEPTH cycles after reset.
- Undefined: no INIT state or counter. The block resets directly into RUN with init_done tied to 1, and SRAM contents are undefined until written.

Test Plan:
- Init clear (macro on, INIT_VALUE=16'hA5A5): release reset → exactly 512 consecutive sram_en=1/wmode=1 writes at addr 0..511, init_done rises the next cycle, then a read of addr 300 returns 16'hA5A5.
- Single requester: req0 write addr 5 = 16'h1234, next cycle req0 read addr 5 → resp0_valid one cycle later with rdata 16'h1234; resp1_valid stays 0.
- Contention: req0 and req1 both hold valid reads for 4 cycles → grants alternate 0,1,0,1 and each resp_valid pulses on the matching requester 1 cycle after its grant.
- Fairness after idle: req1 wins alone, then both request → req0 is granted first.
- Reset mid-INIT: assert reset at init_cnt=200 for one cycle → the write sequence restarts at addr 0 and init_done is delayed by a full 512 cycles.
- Macro off: after reset, init_done=1 and req0_ready=1 in the first cycle; a write then read of addr 511 = 16'hFFFF returns 16'hFFFF.
